icu_refill_ctl: RTL and testbench
=================================

// Module: icu_refill_ctl
// PURPOSE
// - I-cache miss/refill sequencer between the icache lookup pipe (ic2) and the BIU.
// - On an ic2 miss it issues one line request, collects LINE_BEATS 64-bit beats and writes them to the data RAM.
// - It writes tag+valid last, forwards the critical (missed) beat to the IFU and pulses done so the IFU replays.
// PARAMETERS
// - LINE_BEATS  4   64-bit beats per cache line (32 B line); power of two
// - IDX_W       7   set-index width; index = addr[IDX_W+4:5]
// - TAG_W       32-IDX_W-5   tag width; tag = addr[31:IDX_W+5]
// PORTS
// - clk                 in   1        clock, all logic on posedge
// - reset               in   1        synchronous, active-high reset
// - miss_ic2            in   1        lookup missed in ic2 (qualified valid request)
// - miss_addr_ic2       in   [31:3]   doubleword address of missing fetch
// - ifu_cancel          in   1        IFU redirect; drop critical-beat forward
// - icu_biu_req         out  1        line read request, held until ack
// - icu_biu_addr        out  [31:3]   line-aligned address (beat bits zero)
// - biu_icu_ack         in   1        request accepted (1-cycle pulse)
// - biu_icu_data_valid  in   1        beat valid
// - biu_icu_data        in   64       beat data, beats return in order 0..LINE_BEATS-1
// - biu_icu_data_last   in   1        final beat of burst
// - data_wen            out  1        data RAM write strobe
// - data_widx           out  IDX_W    data RAM set index
// - data_wbeat          out  2        beat (doubleword) within line
// - data_wdata          out  64       data RAM write data
// - tag_wen             out  1        tag/valid RAM write strobe
// - tag_widx            out  IDX_W    tag RAM set index
// - tag_wdata           out  TAG_W    tag value (valid bit written 1 with it)
// - refill_busy         out  1        controller not IDLE; icache lookup must not ack
// - crit_valid          out  1        critical beat forwarded this cycle
// - crit_data           out  64       critical beat data
// - refill_done         out  1        1-cycle pulse, line valid in cache
// - refill_err          out  1        1-cycle pulse, short burst, line not validated
// BEHAVIOUR
// - Reset: state IDLE; every output 0; beat counter 0; latched address 0; reset mid-burst abandons refill, no tag write.
// - IDLE: miss_ic2=1 -> latch miss_addr_ic2, cancel flag clear -> REQ (next cycle). Misses arriving while busy ignored.
// - REQ: icu_biu_req=1, icu_biu_addr={latched[31:5],2'b00}, stable until biu_icu_ack; ack -> WAIT_DATA.
// - WAIT_DATA: each data_valid -> data_wen=1 same cycle (combinational from beat), wbeat=counter, counter++ (wraps mod LINE_BEATS).
// - Critical beat: when counter == latched[4:3] and data_valid and cancel flag clear -> crit_valid=1, crit_data=biu_icu_data, same cycle.
// - ifu_cancel in any non-IDLE state sets cancel flag; burst still drained and line still written (bus must complete).
// - ifu_cancel in the same cycle as the critical beat suppresses crit_valid.
// - data_last with counter == LINE_BEATS-1 -> TAG: next cycle tag_wen=1, tag_widx/tag_wdata from latched addr -> DONE.
// - data_last with counter < LINE_BEATS-1 -> ERR: no tag_wen, refill_err pulse, -> IDLE.
// - Beat LINE_BEATS-1 arriving without data_last is treated as last (same as above); beats after last ignored.
// - DONE: refill_done=1 for one cycle -> IDLE; refill_busy=0 from the following cycle; a new miss may be accepted in that cycle.
// - refill_busy=1 in REQ, WAIT_DATA, TAG, DONE/ERR.
// - Latency: miss -> req 1 cycle; last beat -> tag_wen 1 cycle; tag_wen -> done 1 cycle.
// STRUCTURE
// - icu_pkg: state encoding (IDLE, REQ, WAIT_DATA, TAG, DONE, ERR), LINE_BEATS, line-offset/index/tag field-slice constants.
// - Single module, no sub-module; FSM + beat counter + address/cancel latches.
// TESTING
// - Miss addr 29'h2021 (line 0x10100, beat 1); ack after 3 cycles; beats aa..,bb..,cc..,dd.. -> icu_biu_addr=29'h2020, data_wen x4 beats 0..3, crit_data=bbbb_bbbb_bbbb_bbbb, tag_wen idx=0x08, refill_done once.
// - Same miss, ifu_cancel asserted in WAIT_DATA before beat 1 -> crit_valid never 1; all 4 data_wen plus tag_wen still occur.
// - data_last on beat 2 -> refill_err pulse, no tag_wen, refill_busy 0 next cycle.
// - Second miss 29'h2022 during an active refill -> ignored; same miss after refill_done -> new request, crit beat 2 forwarded.
// - Reset asserted between beats 1 and 2 -> all outputs 0 next cycle, no tag_wen, IDLE accepts new miss.
// - Ack delayed 20 cycles -> icu_biu_req and icu_biu_addr stable throughout, single request issued.

Source files
------------

// File: rtl/icu_refill_ctl_pkg.sv
// I-cache refill controller: shared constants and state encoding.
// Field slices assume a 32-byte line addressed as doublewords [31:3].
package icu_refill_ctl_pkg;

  localparam int ICU_LINE_BEATS = 4;
  localparam int ICU_IDX_W      = 7;
  localparam int ICU_TAG_W      = 32 - ICU_IDX_W - 5;
  localparam int ICU_OFF_LSB    = 3;
  localparam int ICU_IDX_LSB    = 5;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_DATA,
    TAG,
    DONE,
    ERR
  } icu_state_t;

endpackage

// File: rtl/icu_refill_ctl_if.sv
// BIU line-read channel between the refill controller and the bus unit.
// master = refill controller, slave = BIU.
interface icu_refill_ctl_if;

  logic        icu_biu_req;
  logic [31:3] icu_biu_addr;
  logic        biu_icu_ack;
  logic        biu_icu_data_valid;
  logic [63:0] biu_icu_data;
  logic        biu_icu_data_last;

  modport master (
    output icu_biu_req,
    output icu_biu_addr,
    input  biu_icu_ack,
    input  biu_icu_data_valid,
    input  biu_icu_data,
    input  biu_icu_data_last
  );

  modport slave (
    input  icu_biu_req,
    input  icu_biu_addr,
    output biu_icu_ack,
    output biu_icu_data_valid,
    output biu_icu_data,
    output biu_icu_data_last
  );

endinterface

// File: rtl/icu_refill_ctl.sv
// I-cache miss/refill sequencer: one line request, beat writes,
// tag write last, critical-beat forward and done/err pulses.
module icu_refill_ctl
  import icu_refill_ctl_pkg::*;
#(
  parameter int LINE_BEATS = ICU_LINE_BEATS,
  parameter int IDX_W      = ICU_IDX_W,
  parameter int TAG_W      = 32 - IDX_W - 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          miss_ic2,
  input  logic [31:3]                   miss_addr_ic2,
  input  logic                          ifu_cancel,
  icu_refill_ctl_if.master              biu,
  output logic                          data_wen,
  output logic [IDX_W-1:0]              data_widx,
  output logic [$clog2(LINE_BEATS)-1:0] data_wbeat,
  output logic [63:0]                   data_wdata,
  output logic                          tag_wen,
  output logic [IDX_W-1:0]              tag_widx,
  output logic [TAG_W-1:0]              tag_wdata,
  output logic                          refill_busy,
  output logic                          crit_valid,
  output logic [63:0]                   crit_data,
  output logic                          refill_done,
  output logic                          refill_err
);

  localparam int BW = $clog2(LINE_BEATS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_BEATS - 1);

  icu_state_t  r_state;
  icu_state_t  w_next;
  logic [31:3] r_addr;
  logic [BW-1:0] r_cnt;
  logic        r_cancel;

  logic w_accept;
  logic w_beat;
  logic w_full;
  logic w_last;
  logic w_crit;

  assign w_accept = (r_state == IDLE) && miss_ic2;
  assign w_beat   = (r_state == WAIT_DATA) && biu.biu_icu_data_valid;
  assign w_full   = (r_cnt == LAST_BEAT);
  // The final beat slot closes the burst even if the BIU omits last.
  assign w_last   = w_beat && (biu.biu_icu_data_last || w_full);
  assign w_crit   = w_beat && (r_cnt == r_addr[BW+2:3])
                 && !r_cancel && !ifu_cancel;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:      if (miss_ic2) w_next = REQ;
      REQ:       if (biu.biu_icu_ack) w_next = WAIT_DATA;
      WAIT_DATA: if (w_last) w_next = w_full ? TAG : ERR;
      TAG:       w_next = DONE;
      DONE:      w_next = IDLE;
      ERR:       w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_cnt    <= '0;
      r_cancel <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr   <= miss_addr_ic2;
        r_cnt    <= '0;
        r_cancel <= 1'b0;
      end else begin
        if ((r_state != IDLE) && ifu_cancel) r_cancel <= 1'b1;
        if (w_beat) r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign biu.icu_biu_req  = (r_state == REQ);
  assign biu.icu_biu_addr = {r_addr[31:BW+3], {BW{1'b0}}};

  assign data_wen   = w_beat;
  assign data_widx  = r_addr[IDX_W+4:5];
  assign data_wbeat = r_cnt;
  assign data_wdata = w_beat ? biu.biu_icu_data : 64'd0;

  assign tag_wen   = (r_state == TAG);
  assign tag_widx  = r_addr[IDX_W+4:5];
  assign tag_wdata = r_addr[31:IDX_W+5];

  assign refill_busy = (r_state != IDLE);
  assign crit_valid  = w_crit;
  assign crit_data   = w_crit ? biu.biu_icu_data : 64'd0;
  assign refill_done = (r_state == DONE);
  assign refill_err  = (r_state == ERR);

endmodule

// File: tb/tb_icu_refill_ctl.sv
// Bench for icu_refill_ctl: refill-level reference model compared
// every cycle, plus directed literal checks on the key scenarios.
module tb_icu_refill_ctl;
  import icu_refill_ctl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        miss_ic2;
  logic [31:3] miss_addr_ic2;
  logic        ifu_cancel;
  logic        data_wen;
  logic [6:0]  data_widx;
  logic [1:0]  data_wbeat;
  logic [63:0] data_wdata;
  logic        tag_wen;
  logic [6:0]  tag_widx;
  logic [19:0] tag_wdata;
  logic        refill_busy;
  logic        crit_valid;
  logic [63:0] crit_data;
  logic        refill_done;
  logic        refill_err;

  icu_refill_ctl_if bus ();

  icu_refill_ctl dut (
    .clk          (clk),
    .reset        (reset),
    .miss_ic2     (miss_ic2),
    .miss_addr_ic2(miss_addr_ic2),
    .ifu_cancel   (ifu_cancel),
    .biu          (bus),
    .data_wen     (data_wen),
    .data_widx    (data_widx),
    .data_wbeat   (data_wbeat),
    .data_wdata   (data_wdata),
    .tag_wen      (tag_wen),
    .tag_widx     (tag_widx),
    .tag_wdata    (tag_wdata),
    .refill_busy  (refill_busy),
    .crit_valid   (crit_valid),
    .crit_data    (crit_data),
    .refill_done  (refill_done),
    .refill_err   (refill_err)
  );

  always #5 clk = ~clk;

  localparam int P_IDLE  = 0;
  localparam int P_REQ   = 1;
  localparam int P_BEATS = 2;
  localparam int P_TAG   = 3;
  localparam int P_DONE  = 4;
  localparam int P_ERR   = 5;

  // Refill-level model: where the refill is, beats seen so far, cancel.
  int          m_phase = P_IDLE;
  logic [28:0] m_addr  = '0;
  int          m_seen  = 0;
  bit          m_canc  = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_phase <= P_IDLE;
      m_addr  <= '0;
      m_seen  <= 0;
      m_canc  <= 1'b0;
    end else if (m_phase == P_IDLE) begin
      if (miss_ic2) begin
        m_phase <= P_REQ;
        m_addr  <= miss_addr_ic2;
        m_seen  <= 0;
        m_canc  <= 1'b0;
      end
    end else begin
      if (ifu_cancel) m_canc <= 1'b1;
      if (m_phase == P_REQ && bus.biu_icu_ack) m_phase <= P_BEATS;
      if (m_phase == P_BEATS && bus.biu_icu_data_valid) begin
        m_seen <= m_seen + 1;
        if (m_seen + 1 == 4) m_phase <= P_TAG;
        else if (bus.biu_icu_data_last) m_phase <= P_ERR;
      end
      if (m_phase == P_TAG) m_phase <= P_DONE;
      if (m_phase == P_DONE || m_phase == P_ERR) m_phase <= P_IDLE;
    end
  end

  function automatic logic [199:0] expect_vec();
    logic        beat;
    logic        crit;
    logic [63:0] d;
    beat = (m_phase == P_BEATS) && bus.biu_icu_data_valid;
    d    = beat ? bus.biu_icu_data : 64'd0;
    crit = beat && (m_seen == int'(m_addr[1:0]))
        && !m_canc && !ifu_cancel;
    return {m_phase == P_REQ, m_addr[28:2], 2'b00,
            beat, m_addr[8:2], 2'(m_seen % 4), d,
            m_phase == P_TAG, m_addr[8:2], m_addr[28:9],
            m_phase != P_IDLE, crit, crit ? bus.biu_icu_data : 64'd0,
            m_phase == P_DONE, m_phase == P_ERR};
  endfunction

  function automatic logic [199:0] actual_vec();
    return {bus.icu_biu_req, bus.icu_biu_addr,
            data_wen, data_widx, data_wbeat, data_wdata,
            tag_wen, tag_widx, tag_wdata,
            refill_busy, crit_valid, crit_data,
            refill_done, refill_err};
  endfunction

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  int          n_req, n_addr_chg, n_wen, n_crit, n_tag, n_done, n_err;
  logic [7:0]  beat_log;
  logic [28:0] req_addr;
  logic [63:0] crit_last;
  logic [6:0]  tag_idx;
  logic [19:0] tag_dat;
  logic        p_req = 1'b0;
  logic [28:0] p_addr = '0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic clr_cnt();
    n_req = 0; n_addr_chg = 0; n_wen = 0; n_crit = 0;
    n_tag = 0; n_done = 0; n_err = 0;
    beat_log = '0; req_addr = '0; crit_last = '0;
    tag_idx = '0; tag_dat = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pat(int b);
    case (b)
      0:       return 64'haaaa_aaaa_aaaa_aaaa;
      1:       return 64'hbbbb_bbbb_bbbb_bbbb;
      2:       return 64'hcccc_cccc_cccc_cccc;
      default: return 64'hdddd_dddd_dddd_dddd;
    endcase
  endfunction

  task automatic refill(input logic [28:0] a, input int ack_dly,
                        input int nbeats, input int canc_before,
                        input int canc_with, input int rst_after,
                        input bit rnd, input bit miss_during,
                        input bit omit_last, input bit extra);
    int n;
    miss_ic2 = 1'b1;
    miss_addr_ic2 = a;
    step();
    miss_ic2 = 1'b0;
    repeat (ack_dly) step();
    bus.biu_icu_ack = 1'b1;
    step();
    bus.biu_icu_ack = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      if (rnd) repeat ($urandom_range(0, 2)) step();
      if (canc_before == b) begin
        ifu_cancel = 1'b1;
        step();
        ifu_cancel = 1'b0;
      end
      bus.biu_icu_data_valid = 1'b1;
      bus.biu_icu_data = rnd ? {$urandom, $urandom} : pat(b);
      bus.biu_icu_data_last = (b == nbeats - 1) && !omit_last;
      ifu_cancel = (canc_with == b);
      miss_ic2 = miss_during;
      miss_addr_ic2 = a + 29'd1;
      step();
      bus.biu_icu_data_valid = 1'b0;
      bus.biu_icu_data_last = 1'b0;
      bus.biu_icu_data = '0;
      ifu_cancel = 1'b0;
      miss_ic2 = 1'b0;
      if (rst_after == b) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
        return;
      end
    end
    if (extra) begin
      bus.biu_icu_data_valid = 1'b1;
      bus.biu_icu_data = {$urandom, $urandom};
      step();
      bus.biu_icu_data_valid = 1'b0;
      bus.biu_icu_data = '0;
    end
    n = 0;
    while (refill_busy && n < 20) begin
      step();
      n++;
    end
    if (refill_busy) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout act=1 exp=0");
    end
  endtask

  initial begin
    reset = 1'b1;
    miss_ic2 = 1'b0;
    miss_addr_ic2 = '0;
    ifu_cancel = 1'b0;
    bus.biu_icu_ack = 1'b0;
    bus.biu_icu_data_valid = 1'b0;
    bus.biu_icu_data = '0;
    bus.biu_icu_data_last = 1'b0;
    clr_cnt();
    fork
      forever begin
        @(negedge clk);
        if (mon_en) begin
          checks++;
          if (actual_vec() !== expect_vec()) begin
            errors++;
            $display("FAIL cycle t=%0t act=%h exp=%h",
                     $time, actual_vec(), expect_vec());
          end
          if (bus.icu_biu_req && !p_req) begin
            n_req++;
            req_addr = bus.icu_biu_addr;
          end
          if (bus.icu_biu_req && p_req && bus.icu_biu_addr != p_addr)
            n_addr_chg++;
          p_req = bus.icu_biu_req;
          p_addr = bus.icu_biu_addr;
          if (data_wen) begin
            n_wen++;
            beat_log = {beat_log[5:0], data_wbeat};
          end
          if (crit_valid) begin
            n_crit++;
            crit_last = crit_data;
          end
          if (tag_wen) begin
            n_tag++;
            tag_idx = tag_widx;
            tag_dat = tag_wdata;
          end
          if (refill_done) n_done++;
          if (refill_err) n_err++;
        end
      end
      begin
        step();
        mon_en = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_outputs", 64'(actual_vec() != '0), 64'd0);
        chk("rst_busy", 64'(refill_busy), 64'd0);
        step();

        clr_cnt();
        refill(29'h2021, 3, 4, -1, -1, -1, 0, 0, 0, 0);
        chk("A_req_cnt", n_req, 1);
        chk("A_req_addr", 64'(req_addr), 64'h2020);
        chk("A_wen_cnt", n_wen, 4);
        chk("A_beat_order", 64'(beat_log), 64'h1b);
        chk("A_crit_cnt", n_crit, 1);
        chk("A_crit_data", crit_last, 64'hbbbb_bbbb_bbbb_bbbb);
        chk("A_tag_cnt", n_tag, 1);
        chk("A_tag_idx", 64'(tag_idx), 64'h08);
        chk("A_tag_data", 64'(tag_dat), 64'h10);
        chk("A_done_cnt", n_done, 1);
        chk("A_err_cnt", n_err, 0);

        clr_cnt();
        refill(29'h2021, 1, 4, 1, -1, -1, 0, 0, 0, 0);
        chk("B_crit_cnt", n_crit, 0);
        chk("B_wen_cnt", n_wen, 4);
        chk("B_tag_cnt", n_tag, 1);

        clr_cnt();
        refill(29'h2021, 0, 3, -1, -1, -1, 0, 0, 0, 0);
        chk("C_err_cnt", n_err, 1);
        chk("C_tag_cnt", n_tag, 0);
        chk("C_done_cnt", n_done, 0);
        chk("C_busy", 64'(refill_busy), 64'd0);

        clr_cnt();
        refill(29'h2021, 2, 4, -1, -1, -1, 0, 1, 0, 0);
        chk("D_req_cnt", n_req, 1);
        chk("D_crit_data", crit_last, 64'hbbbb_bbbb_bbbb_bbbb);
        clr_cnt();
        refill(29'h2022, 2, 4, -1, -1, -1, 0, 0, 0, 0);
        chk("D2_req_cnt", n_req, 1);
        chk("D2_crit_data", crit_last, 64'hcccc_cccc_cccc_cccc);

        clr_cnt();
        refill(29'h2021, 1, 4, -1, -1, 1, 0, 0, 0, 0);
        chk("E_outputs_zero", 64'(actual_vec() != '0), 64'd0);
        chk("E_tag_cnt", n_tag, 0);
        clr_cnt();
        refill(29'h2021, 1, 4, -1, -1, -1, 0, 0, 0, 0);
        chk("E2_done_cnt", n_done, 1);

        clr_cnt();
        refill(29'h2021, 20, 4, -1, -1, -1, 0, 0, 0, 0);
        chk("F_req_cnt", n_req, 1);
        chk("F_addr_chg", n_addr_chg, 0);
        chk("F_req_addr", 64'(req_addr), 64'h2020);

        clr_cnt();
        refill(29'h2021, 1, 4, -1, 1, -1, 0, 0, 0, 0);
        chk("G_crit_cnt", n_crit, 0);
        chk("G_tag_cnt", n_tag, 1);

        clr_cnt();
        refill(29'h2023, 0, 4, -1, -1, -1, 0, 0, 1, 1);
        chk("H_tag_cnt", n_tag, 1);
        chk("H_wen_cnt", n_wen, 4);

        for (int it = 0; it < 40; it++) begin
          int nb;
          nb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 4;
          refill(29'($urandom), $urandom_range(0, 5), nb,
                 $urandom_range(0, 7), $urandom_range(0, 7),
                 ($urandom_range(0, 9) == 0) ? $urandom_range(0, nb - 1) : -1,
                 1, $urandom_range(0, 1), (nb == 4) && ($urandom_range(0, 3) == 0),
                 $urandom_range(0, 1));
          repeat ($urandom_range(0, 2)) step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    join_any
  end

endmodule
